// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states,
// iterative-unit modes and flag-vector bit positions.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_NOT   = 4'd0;
  localparam op_t OP_AND   = 4'd1;
  localparam op_t OP_XOR   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_DEC   = 4'd4;
  localparam op_t OP_ADD   = 4'd5;
  localparam op_t OP_SUB   = 4'd6;
  localparam op_t OP_INC   = 4'd7;
  localparam op_t OP_SLL   = 4'd8;
  localparam op_t OP_SRL   = 4'd9;
  localparam op_t OP_SRA   = 4'd10;
  localparam op_t OP_SLT   = 4'd11;
  localparam op_t OP_MULU  = 4'd12;
  localparam op_t OP_DIVU  = 4'd13;
  localparam op_t OP_ILL14 = 4'd14;
  localparam op_t OP_ILL15 = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_t;

  localparam int FLAG_W  = 6;
  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_DBZ = 4;
  localparam int FLG_ILL = 5;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle between the execute stage and the multi-cycle ALU.
interface alu_mc_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_dbz;
  logic             flag_ill;

  // Execute-stage side: issues operations, consumes results
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  flag_z, flag_n, flag_c, flag_v, flag_dbz, flag_ill
  );

  // ALU side
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
    output flag_z, flag_n, flag_c, flag_v, flag_dbz, flag_ill
  );

endinterface

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) datapath.
// One iteration per clock; done is high during the last iteration and
// lo/hi then present the post-iteration values so the caller can register
// them on that same edge.
module alu_mc_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  iter_mode_t       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;     // product high word / partial remainder
  logic [WIDTH-1:0] shr;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opnd;    // multiplicand / divisor
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] shr_nxt;
  logic [WIDTH:0]   madd;
  logic [WIDTH:0]   trial;
  logic             fits;

  // One iteration of the selected algorithm
  always_comb begin
    acc_nxt = acc;
    shr_nxt = shr;
    madd    = '0;
    trial   = '0;
    fits    = 1'b0;
    if (mode_q == MODE_MUL) begin
      // Add multiplicand when multiplier LSB is set, then shift the
      // whole {carry, acc, shr} right by one.
      madd    = {1'b0, acc} + (shr[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
      acc_nxt = madd[WIDTH:1];
      shr_nxt = {madd[0], shr[WIDTH-1:1]};
    end else begin
      // Bring down the next dividend bit (MSB first) and trial-subtract.
      trial = {acc, shr[WIDTH-1]};
      fits  = (trial >= {1'b0, opnd});
      if (fits) begin
        acc_nxt = WIDTH'(trial - {1'b0, opnd});
      end else begin
        acc_nxt = trial[WIDTH-1:0];
      end
      shr_nxt = {shr[WIDTH-2:0], fits};
    end
  end

  // Working registers and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_MUL;
      cnt    <= '0;
      acc    <= '0;
      shr    <= '0;
      opnd   <= '0;
    end else if (start) begin
      mode_q <= mode;
      cnt    <= CNT_W'(WIDTH);
      acc    <= '0;
      shr    <= a;
      opnd   <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      acc <= acc_nxt;
      shr <= shr_nxt;
    end
  end

  assign done = (cnt == CNT_W'(1));
  assign lo   = shr_nxt;
  assign hi   = acc_nxt;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift/compare ops plus
// iterative MULU/DIVU, with valid/ready on both sides and a full flag set.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_mc_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  state_t              state;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [WIDTH-1:0]    res_q;
  logic [WIDTH-1:0]    hi_q;
  logic [FLAG_W-1:0]   flg_q;

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [SHW-1:0]      sh;
  logic [WIDTH-1:0]    addend;
  logic                cin;
  logic                is_sub;
  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    res_c;
  logic [WIDTH-1:0]    hi_c;
  logic                c_c;
  logic                v_c;
  logic                dbz_c;
  logic                ill_c;
  logic [FLAG_W-1:0]   flg_c;

  logic                accept;
  logic                use_iter;
  logic                iter_done;
  logic [WIDTH-1:0]    iter_lo;
  logic [WIDTH-1:0]    iter_hi;
  iter_mode_t          iter_mode;

  function automatic logic [FLAG_W-1:0] mk_flags(input logic [WIDTH-1:0] r,
                                                 input logic c, input logic v,
                                                 input logic dbz, input logic ill);
    logic [FLAG_W-1:0] f;
    f          = '0;
    f[FLG_Z]   = (r == '0);
    f[FLG_N]   = r[WIDTH-1];
    f[FLG_C]   = c;
    f[FLG_V]   = v;
    f[FLG_DBZ] = dbz;
    f[FLG_ILL] = ill;
    return f;
  endfunction

  assign a_s = bus.a;
  assign b_s = bus.b;
  assign sh  = bus.b[SHW-1:0];

  // Single-cycle result and flags for the op currently presented
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    is_sub = 1'b0;
    res_c  = '0;
    hi_c   = '0;
    c_c    = 1'b0;
    v_c    = 1'b0;
    dbz_c  = 1'b0;
    ill_c  = 1'b0;
    // Adder operand selection: subtraction is A + ~B + 1
    case (bus.op)
      OP_DEC:  begin addend = ~WIDTH'(1); cin = 1'b1; is_sub = 1'b1; end
      OP_ADD:  begin addend = bus.b; end
      OP_SUB:  begin addend = ~bus.b; cin = 1'b1; is_sub = 1'b1; end
      OP_INC:  begin cin = 1'b1; end
      default: ;
    endcase
    sum = {1'b0, bus.a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};
    case (bus.op)
      OP_NOT: res_c = ~bus.a;
      OP_AND: res_c = bus.a & bus.b;
      OP_XOR: res_c = bus.a ^ bus.b;
      OP_OR:  res_c = bus.a | bus.b;
      OP_DEC, OP_ADD, OP_SUB, OP_INC: begin
        res_c = sum[WIDTH-1:0];
        c_c   = is_sub ? ~sum[WIDTH] : sum[WIDTH];
        v_c   = (bus.a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SLL: res_c = bus.a << sh;
      OP_SRL: res_c = bus.a >> sh;
      OP_SRA: res_c = a_s >>> sh;
      OP_SLT: res_c = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_DIVU: begin
        // Only reaches the output registers when b == 0
        res_c = '1;
        hi_c  = bus.a;
        dbz_c = 1'b1;
      end
      OP_ILL14, OP_ILL15: ill_c = 1'b1;
      default: ;
    endcase
    flg_c = mk_flags(res_c, c_c, v_c, dbz_c, ill_c);
  end

  assign accept    = (state == ST_IDLE) && in_ready_q && bus.in_valid;
  assign use_iter  = (bus.op == OP_MULU) || ((bus.op == OP_DIVU) && (bus.b != '0));
  assign iter_mode = (bus.op == OP_DIVU) ? MODE_DIV : MODE_MUL;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && use_iter),
    .mode  (iter_mode),
    .a     (bus.a),
    .b     (bus.b),
    .done  (iter_done),
    .lo    (iter_lo),
    .hi    (iter_hi)
  );

  // Control FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      hi_q        <= '0;
      flg_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            if (use_iter) begin
              state <= ST_CALC;
            end else begin
              res_q       <= res_c;
              hi_q        <= hi_c;
              flg_q       <= flg_c;
              out_valid_q <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_CALC: begin
          if (iter_done) begin
            res_q       <= iter_lo;
            hi_q        <= iter_hi;
            flg_q       <= mk_flags(iter_lo, 1'b0, 1'b0, 1'b0, 1'b0);
            out_valid_q <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = res_q;
  assign bus.result_hi = hi_q;
  assign bus.flag_z    = flg_q[FLG_Z];
  assign bus.flag_n    = flg_q[FLG_N];
  assign bus.flag_c    = flg_q[FLG_C];
  assign bus.flag_v    = flg_q[FLG_V];
  assign bus.flag_dbz  = flg_q[FLG_DBZ];
  assign bus.flag_ill  = flg_q[FLG_ILL];

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU, the successor to the processor's 32-bit combinational ALU.
- Keeps the existing 3-bit operation set and adds shifts, set-less-than, iterative unsigned multiply and iterative unsigned divide.
- Exposes a full flag set (Z, N, C, V, DBZ, ILL) and valid/ready handshakes on both sides, so the execute stage can stall on long operations.

Parameters:
- WIDTH, 32, operand/result width; legal values ≥ 4, power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  primary result (MUL low word, DIV quotient).
- result_hi  out  WIDTH  MUL high word or DIV remainder; 0 for all other ops.
- flag_z  out  1  result == 0 (result_hi ignored).
- flag_n  out  1  result[WIDTH-1].
- flag_c  out  1  ADD: carry-out; SUB/DEC: borrow; INC: carry-out; otherwise 0.
- flag_v  out  1  signed overflow for ADD/SUB/INC/DEC; otherwise 0.
- flag_dbz  out  1  DIVU with b == 0.
- flag_ill  out  1  op 14 or 15.

Behaviour:
- Opcodes:
  - 0 NOT A; 1 AND; 2 XOR; 3 OR; 4 A-1; 5 A+B; 6 A-B; 7 A+1.
  - 8 SLL A by b[SHW-1:0]; 9 SRL; 10 SRA.
  - 11 SLT: signed A<B gives 1, else 0.
  - 12 MULU; 13 DIVU; 14/15 illegal.
- Reset (rst_n low, any state, including mid-MUL/DIV):
  - State goes to IDLE; iteration counter and working registers clear.
  - result, result_hi and all flags go to 0; out_valid 0; in_ready 1 from the first edge after rst_n rises.
  - A partially computed operation is discarded, with no output.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready=1. On in_valid, capture op, a and b.
    - Ops 0–11, 14, 15, and DIVU with b==0: compute and register result and flags, then go to DONE.
    - Ops 12/13 otherwise: load working registers, set counter to WIDTH, go to CALC.
  - CALC: one iteration per cycle; decrement counter; after the iteration that takes the counter to 0, register outputs and go to DONE. in_valid is ignored.
  - DONE: out_valid=1. Outputs and flags are held stable until out_ready. Transfer edge: go to IDLE, out_valid drops.
- Back-to-back operation:
  - No bypass DONE→accept in the same cycle; in_ready stays 0 in DONE.
  - Throughput for a simple op is one operation per 2 cycles with out_ready held high.
- Latency (accept edge to out_valid high):
  - Ops 0–11, 14, 15 and DBZ: 1 cycle.
  - MULU/DIVU: WIDTH+1 cycles.
- Arithmetic:
  - ADD/SUB/INC/DEC use a WIDTH+1-bit internal sum; C comes from bit WIDTH.
  - SUB/DEC borrow is the inverse of the carry-out of A+~B+1.
  - V is computed from the new sum's sign bit, never from a previously registered value.
  - Shifts use only b[SHW-1:0]; the upper bits of b are ignored.
- MULU:
  - Shift-add over a 2·WIDTH product; the LSB of the multiplier is examined each iteration.
  - {result_hi, result} = a*b, unsigned.
- DIVU:
  - Restoring, one quotient bit per iteration, MSB first.
  - result = a/b, result_hi = a%b.
- Divide by zero: result = all ones, result_hi = a, flag_dbz=1, 1-cycle latency.
- Illegal op: result = 0, result_hi = 0, flag_ill=1, flag_z=1.
- Z and N are evaluated on the final registered result for every op.

Decomposition:
- Shared package alu_pkg:
  - op-code constants OP_NOT…OP_DIVU, OP_ILL14/15;
  - 4-bit op typedef;
  - FSM state typedef;
  - flag-vector field indices.
- One natural sub-module, alu_mc_iter: the MUL/DIV iterative datapath.
  - Holds the counter, accumulator and shift registers.
  - Interface: start, mode, a, b, done, lo, hi.
- Single-cycle ops stay combinational inside alu_mc, feeding the output registers.

Test Plan:
- Reset mid-MUL:
  - Stimulus: start MULU a=7, b=9; drop rst_n at CALC cycle 5.
  - Required response: all outputs 0, out_valid 0, in_ready 1 after release; the next op 5 (A+B) a=1, b=2 returns 3 with 1-cycle latency.
- ADD overflow (WIDTH=32):
  - Stimulus: ADD a=0x7FFFFFFF, b=1.
  - Required response: result 0x80000000, V=1, N=1, C=0, Z=0.
  - Stimulus: ADD a=0xFFFFFFFF, b=1.
  - Required response: result 0, C=1, Z=1, V=0.
- SUB borrow, SRA and SLT:
  - Stimulus: SUB a=0, b=1. Required response: 0xFFFFFFFF, C=1, N=1.
  - Stimulus: SRA a=0x80000000, b=0x24 (shift 4). Required response: 0xF8000000.
  - Stimulus: SLT a=-1, b=0. Required response: 1.
- MULU:
  - Stimulus: MULU a=0xFFFFFFFF, b=0xFFFFFFFF.
  - Required response: out_valid exactly 33 cycles after accept; result_hi=0xFFFFFFFE, result=0x00000001.
- DIVU:
  - Stimulus: DIVU a=100, b=7. Required response: q=14, r=2, 33-cycle latency.
  - Stimulus: DIVU a=5, b=0. Required response: result 0xFFFFFFFF, result_hi 5, dbz=1, 1-cycle latency.
- Backpressure and illegal op:
  - Stimulus: hold out_ready=0 for 10 cycles in DONE.
  - Required response: outputs stable, in_ready=0, new in_valid ignored.
  - Stimulus: op 15.
  - Required response: flag_ill=1, result 0.
